grid_target_renderer: RTL and testbench
=======================================

# grid_target_renderer

Parametrised successor to the fixed 3x3 square display: renders a COLS x ROWS grid of target cells onto the 640x480 VGA pixel stream, with a registered per-cell state machine instead of purely combinational colouring. Target and hit inputs are captured with frame-synchronous updates, so the picture never tears mid-frame. Hits and misses produce timed colour flashes, and a saturating hit score is kept. Sits between the vga640x480 timing generator and the VGA colour pins.

## Interface
- COLS, default 3: grid columns (1..8)
- ROWS, default 3: grid rows (1..8)
- ORIGIN_X / ORIGIN_Y, default 100 / 60: top-left pixel of cell (0,0)
- CELL_W / CELL_H, default 80 / 80: cell size in pixels
- PITCH_X / PITCH_Y, default 180 / 140: cell-to-cell spacing; must be >= CELL_W / CELL_H
- CENTER_MASK, default 1: when 1 and COLS, ROWS are both odd, the centre cell is never drawn and ignores inputs
- FLASH_FRAMES, default 30: flash duration in frames (1..255)
- N (localparam) = COLS*ROWS; cell index i = row*COLS + col
- CLK  in  1  system clock (100 MHz)
- RST  in  1  asynchronous, active-high reset
- i_pix_stb  in  1  pixel strobe (25 MHz enable); all pixel-path registers advance only on it
- i_x  in  10  current pixel x
- i_y  in  9  current pixel y
- i_frame  in  1  one-CLK pulse at the start of vertical blank, coincident with a pix_stb
- i_target  in  N  per-cell target request (level)
- i_hit  in  N  per-cell hit input (level, unsynchronised button/sensor level already debounced)
- o_r / o_g / o_b  out  4 each  registered colour
- o_score  out  8  saturating hit count

## Operation
- Hit capture: per cell, a rising edge of i_hit (compared against the previous-CLK value) sets pending[i]. pending clears on i_frame after being consumed. Edges arriving in the same CLK as i_frame go into the next frame.
- Cell FSM, evaluated only on i_frame, using latched target t = i_target[i] and p = pending[i]:
  - OFF: p -> MISS; else t -> ARMED
  - ARMED: p -> HIT; else !t -> OFF
  - HIT / MISS: counter loads FLASH_FRAMES-1 on entry and decrements each i_frame. At 0 the cell goes to ARMED if t, else OFF. A p during a flash is discarded.
- Hit takes priority over target in the same frame.
- Score: on each i_frame, o_score += number of cells entering HIT, saturating at 255 (never wraps).
- Colours (pixel inside cell i):
  - OFF: R=F
  - ARMED: R=F, G=F
  - HIT: G=F
  - MISS: R=F, B=F, blanked on frames where counter[2]=1 (blink)
- Pixels outside every cell, and masked-centre pixels, are 0.
- Cell hit test: x in [ORIGIN_X+col*PITCH_X, +CELL_W), same form for y. Cell boundaries are compile-time constants; no divider.

## Timing
- Pixel path is two pix_stb stages:
  - stage 1: registers cell index and inside flag
  - stage 2: registers RGB from the state
- Latency is 2 pixel strobes. The integrator delays HS/VS by 2 strobes to match. Outputs hold between strobes.
- State changes at i_frame take effect on the first visible pixel of the next frame. No state changes during active video.
- o_score updates 1 CLK after i_frame.
- Reset values: all cells OFF, counters 0, pending 0, prev-hit 0, pipeline 0, o_r/o_g/o_b 0, o_score 0.
- Reset asserted mid-flash returns the cell to OFF immediately. After RST deasserts, the first i_frame evaluates from OFF.
- Masked centre: state is forced OFF, and its hits are never counted.

## Structure
- Package grid_pkg holds:
  - cell_state_t (OFF, ARMED, HIT, MISS)
  - colour constants for each state
  - function cell_lo(idx, origin, pitch) for boundary constants
- Sub-module grid_cell: one cell's edge detector, pending flag, FSM and flash counter. Outputs are state and counter[2]. It is instantiated N times by generate.
- The top level holds the pixel pipeline, the popcount/score adder and the centre mask.

## Test plan
- Reset, then all i_target=0, i_hit=0 for 2 frames -> each cell interior pixel R=F, G=0, B=0; gap pixel (x=200,y=100) is 0; centre (320,240) is 0.
- i_target[0]=1, then i_frame -> pixel (140,100) R=F, G=F exactly 2 strobes after it is presented.
- ARMED cell 0, i_hit[0] pulses mid-frame -> next frame cell 0 green for 30 frames, o_score=1. Cell returns to yellow at frame 31 if target is held.
- OFF cell 2 hit -> magenta blinking, with 4-frame on/off phases, for 30 frames; o_score unchanged. A second hit during the flash is ignored.
- Score preloaded to 254, then 3 cells hit in one frame -> o_score=255, and it stays 255 on later hits.
- RST asserted during a HIT flash -> all outputs 0 immediately. After release, the cell is OFF and red on the next frame.

Source files
------------

// File: rtl/grid_target_renderer_pkg.sv
// grid_pkg: shared types and constants for grid_target_renderer.
//   cell_state_t : per-cell display state
//   RGB_*        : 12-bit {R,G,B} colour per state
//   cell_lo()    : first pixel coordinate of a cell along one axis
package grid_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIT   = 2'd2,
        ST_MISS  = 2'd3
    } cell_state_t;

    // Cell index width; covers the 8x8 maximum grid.
    localparam int IDX_W = 6;

    localparam logic [11:0] RGB_BLACK = 12'h000;
    localparam logic [11:0] RGB_OFF   = 12'hF00;
    localparam logic [11:0] RGB_ARMED = 12'hFF0;
    localparam logic [11:0] RGB_HIT   = 12'h0F0;
    localparam logic [11:0] RGB_MISS  = 12'hF0F;

    function automatic int cell_lo(input int idx, input int origin, input int pitch);
        return origin + idx * pitch;
    endfunction

endpackage

// File: rtl/grid_target_renderer_cell.sv
// grid_cell: one grid cell's hit edge detector, pending flag, state machine
// and flash counter. All state moves only on i_frame (vertical blank).
//   CLK, RST    : clock, async active-high reset
//   i_frame     : start-of-vblank pulse
//   i_target    : target request level for this cell
//   i_hit       : hit level for this cell
//   o_state     : current cell state
//   o_blink     : flash counter bit 2 (MISS blink phase)
//   o_hit_evt   : high in the i_frame cycle in which the cell enters HIT
module grid_cell
    import grid_pkg::*;
#(
    parameter int FLASH_FRAMES = 30
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_frame,
    input  logic        i_target,
    input  logic        i_hit,
    output cell_state_t o_state,
    output logic        o_blink,
    output logic        o_hit_evt
);

    logic        r_prev_hit;
    logic        r_pending;
    logic [7:0]  r_cnt;
    cell_state_t r_state;
    logic        w_rise;

    assign w_rise    = i_hit & ~r_prev_hit;
    assign o_state   = r_state;
    assign o_blink   = r_cnt[2];
    assign o_hit_evt = i_frame & (r_state == ST_ARMED) & r_pending;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_prev_hit <= 1'b0;
            r_pending  <= 1'b0;
            r_cnt      <= 8'd0;
            r_state    <= ST_OFF;
        end else begin
            r_prev_hit <= i_hit;
            if (i_frame) begin
                // Pending is consumed (or discarded during a flash) here; an
                // edge in this same cycle carries into the next frame.
                r_pending <= w_rise;
                case (r_state)
                    ST_OFF: begin
                        if (r_pending) begin
                            r_state <= ST_MISS;
                            r_cnt   <= 8'(FLASH_FRAMES - 1);
                        end else if (i_target) begin
                            r_state <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (r_pending) begin
                            r_state <= ST_HIT;
                            r_cnt   <= 8'(FLASH_FRAMES - 1);
                        end else if (!i_target) begin
                            r_state <= ST_OFF;
                        end
                    end
                    default: begin
                        if (r_cnt == 8'd0) r_state <= i_target ? ST_ARMED : ST_OFF;
                        else               r_cnt   <= r_cnt - 8'd1;
                    end
                endcase
            end else if (w_rise) begin
                r_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/grid_target_renderer.sv
// grid_target_renderer: draws a COLS x ROWS grid of target cells onto the
// 640x480 pixel stream with two pix_stb pipeline stages, and keeps a
// saturating hit score.
//   CLK, RST            : 100 MHz clock, async active-high reset
//   i_pix_stb           : pixel enable; pixel pipeline advances only on it
//   i_x, i_y            : current pixel coordinate
//   i_frame             : start-of-vblank pulse
//   i_target, i_hit     : per-cell target / hit levels (index row*COLS+col)
//   o_r, o_g, o_b       : registered colour, 2 strobes after the pixel
//   o_score             : hit count, saturating at 255
module grid_target_renderer
    import grid_pkg::*;
#(
    parameter  int COLS         = 3,
    parameter  int ROWS         = 3,
    parameter  int ORIGIN_X     = 100,
    parameter  int ORIGIN_Y     = 60,
    parameter  int CELL_W       = 80,
    parameter  int CELL_H       = 80,
    parameter  int PITCH_X      = 180,
    parameter  int PITCH_Y      = 140,
    parameter  bit CENTER_MASK  = 1'b1,
    parameter  int FLASH_FRAMES = 30,
    localparam int N            = COLS * ROWS
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_pix_stb,
    input  logic [9:0]   i_x,
    input  logic [8:0]   i_y,
    input  logic         i_frame,
    input  logic [N-1:0] i_target,
    input  logic [N-1:0] i_hit,
    output logic [3:0]   o_r,
    output logic [3:0]   o_g,
    output logic [3:0]   o_b,
    output logic [7:0]   o_score
);

    localparam bit HAS_CENTER = CENTER_MASK && (COLS % 2 == 1) && (ROWS % 2 == 1);
    localparam int CENTER_IDX = (ROWS / 2) * COLS + (COLS / 2);

    cell_state_t w_state [N];
    logic [N-1:0] w_blink;
    logic [N-1:0] w_evt;

    for (genvar gi = 0; gi < N; gi++) begin : g_cell
        if (HAS_CENTER && gi == CENTER_IDX) begin : g_mask
            // Masked centre: permanently OFF, inputs ignored.
            logic w_unused_in;
            assign w_unused_in = i_target[gi] ^ i_hit[gi];
            assign w_state[gi] = ST_OFF;
            assign w_blink[gi] = 1'b0;
            assign w_evt[gi]   = 1'b0;
        end else begin : g_live
            grid_cell #(.FLASH_FRAMES(FLASH_FRAMES)) u_cell (
                .CLK      (CLK),
                .RST      (RST),
                .i_frame  (i_frame),
                .i_target (i_target[gi]),
                .i_hit    (i_hit[gi]),
                .o_state  (w_state[gi]),
                .o_blink  (w_blink[gi]),
                .o_hit_evt(w_evt[gi])
            );
        end
    end

    // Stage 1: locate the cell under (i_x, i_y) by constant-bound compares.
    logic             w_col_hit, w_row_hit, w_inside;
    logic [2:0]       w_col, w_row;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        w_col_hit = 1'b0;
        w_row_hit = 1'b0;
        w_col     = 3'd0;
        w_row     = 3'd0;
        for (int c = 0; c < COLS; c++) begin
            if (int'(i_x) >= cell_lo(c, ORIGIN_X, PITCH_X) &&
                int'(i_x) <  cell_lo(c, ORIGIN_X, PITCH_X) + CELL_W) begin
                w_col_hit = 1'b1;
                w_col     = 3'(c);
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            if (int'(i_y) >= cell_lo(r, ORIGIN_Y, PITCH_Y) &&
                int'(i_y) <  cell_lo(r, ORIGIN_Y, PITCH_Y) + CELL_H) begin
                w_row_hit = 1'b1;
                w_row     = 3'(r);
            end
        end
        w_idx    = IDX_W'(int'(w_row) * COLS + int'(w_col));
        w_inside = w_col_hit && w_row_hit &&
                   !(HAS_CENTER && w_idx == IDX_W'(CENTER_IDX));
    end

    logic             r_inside;
    logic [IDX_W-1:0] r_idx;
    logic [11:0]      r_rgb;

    // Stage 2: colour from the selected cell's state.
    cell_state_t w_sel_state;
    logic        w_sel_blink;
    logic [11:0] w_rgb;

    always_comb begin
        w_sel_state = ST_OFF;
        w_sel_blink = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_state = w_state[i];
                w_sel_blink = w_blink[i];
            end
        end
        w_rgb = RGB_BLACK;
        if (r_inside) begin
            case (w_sel_state)
                ST_OFF:   w_rgb = RGB_OFF;
                ST_ARMED: w_rgb = RGB_ARMED;
                ST_HIT:   w_rgb = RGB_HIT;
                default:  w_rgb = w_sel_blink ? RGB_BLACK : RGB_MISS;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_inside <= 1'b0;
            r_idx    <= '0;
            r_rgb    <= RGB_BLACK;
        end else if (i_pix_stb) begin
            r_inside <= w_inside;
            r_idx    <= w_idx;
            r_rgb    <= w_rgb;
        end
    end

    assign o_r = r_rgb[11:8];
    assign o_g = r_rgb[7:4];
    assign o_b = r_rgb[3:0];

    // Score: add this frame's new hits, clamp at 255 (max 64 per frame).
    logic [6:0] w_nhit;
    logic [8:0] w_sum;
    logic [7:0] r_score;

    always_comb begin
        w_nhit = 7'd0;
        for (int i = 0; i < N; i++) w_nhit = w_nhit + 7'(w_evt[i]);
        w_sum = {1'b0, r_score} + {2'b00, w_nhit};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)          r_score <= 8'd0;
        else if (i_frame) r_score <= w_sum[8] ? 8'hFF : w_sum[7:0];
    end

    assign o_score = r_score;

endmodule

// File: tb/tb_grid_target_renderer.sv
module tb_grid_target_renderer;

    localparam int COLS = 3, ROWS = 3, N = 9, CENTRE = 4;
    localparam int OX = 100, OY = 60, CW = 80, CH = 80, PX = 180, PY = 140;
    localparam int FF = 30;
    localparam logic [8:0] LIVE = 9'h1EF;
    localparam int S_OFF = 0, S_ARMED = 1, S_HIT = 2, S_MISS = 3;

    logic         CLK = 1'b0;
    logic         RST;
    logic         i_pix_stb, i_frame;
    logic [9:0]   i_x;
    logic [8:0]   i_y;
    logic [N-1:0] i_target, i_hit;
    logic [3:0]   o_r, o_g, o_b;
    logic [7:0]   o_score;

    grid_target_renderer dut (
        .CLK(CLK), .RST(RST), .i_pix_stb(i_pix_stb), .i_x(i_x), .i_y(i_y),
        .i_frame(i_frame), .i_target(i_target), .i_hit(i_hit),
        .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_score(o_score)
    );

    always #5 CLK = ~CLK;

    int checks = 0, failures = 0;

    // Reference model: per-cell state, frames elapsed in a flash, pending hit.
    int         m_st  [N];
    int         m_age [N];
    logic [8:0] m_pend, m_prev;
    int         m_score;
    logic [8:0] cur_t, cur_h;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_st[i] = S_OFF; m_age[i] = 0; end
        m_pend = '0; m_prev = '0; m_score = 0;
    endtask

    task automatic model_frame(input logic [8:0] t);
        int hits = 0;
        for (int i = 0; i < N; i++) begin
            if (i == CENTRE) continue;
            case (m_st[i])
                S_OFF:   if (m_pend[i]) begin m_st[i] = S_MISS; m_age[i] = 0; end
                         else if (t[i]) m_st[i] = S_ARMED;
                S_ARMED: if (m_pend[i]) begin m_st[i] = S_HIT; m_age[i] = 0; hits++; end
                         else if (!t[i]) m_st[i] = S_OFF;
                default: if (m_age[i] == FF - 1) m_st[i] = t[i] ? S_ARMED : S_OFF;
                         else m_age[i]++;
            endcase
        end
        m_score = (m_score + hits > 255) ? 255 : m_score + hits;
    endtask

    // Expected colour by division-based cell lookup.
    function automatic int model_rgb(input int x, input int y);
        int c, r, i, cnt;
        if (x < OX || y < OY) return 0;
        c = (x - OX) / PX; r = (y - OY) / PY;
        if (c >= COLS || r >= ROWS || (x - OX) % PX >= CW || (y - OY) % PY >= CH) return 0;
        i = r * COLS + c;
        if (i == CENTRE) return 0;
        case (m_st[i])
            S_OFF:   return 12'hF00;
            S_ARMED: return 12'hFF0;
            S_HIT:   return 12'h0F0;
            default: begin
                cnt = FF - 1 - m_age[i];
                return ((cnt >> 2) & 1) != 0 ? 0 : 12'hF0F;
            end
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int rgb();
        return int'({o_r, o_g, o_b});
    endfunction

    // One CLK with given inputs; model tracks hit edges and frame evaluation.
    task automatic drive(input logic stb, input logic frm, input int x, input int y);
        logic [8:0] rise;
        i_pix_stb = stb; i_frame = frm; i_target = cur_t; i_hit = cur_h;
        i_x = 10'(x); i_y = 9'(y);
        @(posedge CLK); #1;
        rise = cur_h & ~m_prev;
        if (frm) begin model_frame(cur_t); m_pend = rise; end
        else m_pend = m_pend | rise;
        m_prev = cur_h;
        i_pix_stb = 1'b0; i_frame = 1'b0;
    endtask

    task automatic frame();
        drive(1'b1, 1'b1, 0, 0);
        drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    task automatic pulse(input logic [8:0] mask);
        cur_h = cur_h | mask;  drive(1'b0, 1'b0, 0, 0);
        cur_h = cur_h & ~mask; drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic show(input int x, input int y);
        drive(1'b1, 1'b0, x, y);
        drive(1'b1, 1'b0, x, y);
    endtask

    task automatic check_pix(input string name, input int x, input int y);
        show(x, y);
        chk(name, rgb(), model_rgb(x, y));
    endtask

    task automatic check_const(input string name, input int x, input int y, input int exp);
        show(x, y);
        chk(name, rgb(), exp);
    endtask

    typedef struct {
        int    x;
        int    y;
        int    exp;
        string name;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int need, cnt, score0;
        logic [8:0] mask;

        vecs[0]  = '{140, 100, 12'hF00, "c0_red"};
        vecs[1]  = '{320, 100, 12'hF00, "c1_red"};
        vecs[2]  = '{500, 100, 12'hF00, "c2_red"};
        vecs[3]  = '{140, 240, 12'hF00, "c3_red"};
        vecs[4]  = '{320, 240, 12'h000, "centre_dark"};
        vecs[5]  = '{500, 240, 12'hF00, "c5_red"};
        vecs[6]  = '{140, 380, 12'hF00, "c6_red"};
        vecs[7]  = '{320, 380, 12'hF00, "c7_red"};
        vecs[8]  = '{500, 380, 12'hF00, "c8_red"};
        vecs[9]  = '{200, 100, 12'h000, "gap_dark"};
        vecs[10] = '{100,  60, 12'hF00, "c0_topleft"};
        vecs[11] = '{179, 139, 12'hF00, "c0_botright"};
        vecs[12] = '{180,  60, 12'h000, "c0_right_edge"};
        vecs[13] = '{ 99,  60, 12'h000, "c0_left_edge"};

        RST = 1'b1; i_pix_stb = 0; i_frame = 0; i_x = 0; i_y = 0;
        cur_t = '0; cur_h = '0; i_target = '0; i_hit = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_rgb", rgb(), 0);
        chk("reset_score", int'(o_score), 0);
        RST = 1'b0;

        // Idle grid: every live cell red, gaps and centre dark.
        frames(2);
        foreach (vecs[i]) check_const(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].exp);

        // Arm cell 0, verify 2-strobe latency.
        cur_t = 9'h001;
        frame();
        show(200, 100);
        chk("lat_gap", rgb(), 0);
        drive(1'b1, 1'b0, 140, 100);
        chk("lat_1strobe", rgb(), 0);
        drive(1'b1, 1'b0, 140, 100);
        chk("lat_2strobe", rgb(), 12'hFF0);

        // Hit armed cell 0: green for 30 frames, then yellow.
        pulse(9'h001);
        drive(1'b1, 1'b1, 0, 0);
        chk("hit_score_1clk", int'(o_score), 1);
        drive(1'b0, 1'b0, 0, 0);
        check_const("hit_green_f0", 140, 100, 12'h0F0);
        for (int k = 1; k < FF; k++) begin
            frame();
            check_pix("hit_flash", 140, 100);
        end
        chk("hit_green_last", rgb(), 12'h0F0);
        frame();
        check_const("hit_back_yellow", 140, 100, 12'hFF0);

        // Miss on OFF cell 2: blinking magenta, score unchanged, rehit ignored.
        score0 = int'(o_score);
        pulse(9'h004);
        frame();
        check_const("miss_blank_f0", 500, 100, 12'h000);
        chk("miss_score", int'(o_score), score0);
        for (int k = 1; k < FF; k++) begin
            if (k == 5) pulse(9'h004);
            frame();
            check_pix("miss_blink", 500, 100);
            if (k == 26) chk("miss_on_cnt3", rgb(), 12'hF0F);
        end
        frame();
        check_const("miss_end_red", 500, 100, 12'hF00);
        frame();
        check_const("miss_rehit_ignored", 500, 100, 12'hF00);
        chk("miss_score_end", int'(o_score), score0);

        // Score saturation.
        cur_t = LIVE;
        frame();
        while (254 - m_score >= 8) begin
            pulse(LIVE);
            frame();
            chk("sat_round", int'(o_score), m_score);
            frames(FF);
        end
        need = 254 - m_score; cnt = 0; mask = '0;
        for (int b = 0; b < N; b++)
            if (LIVE[b] && cnt < need) begin mask[b] = 1'b1; cnt++; end
        pulse(mask);
        frame();
        chk("sat_254", int'(o_score), 254);
        frames(FF);
        pulse(9'h007);
        frame();
        chk("sat_255", int'(o_score), 255);
        frames(FF);
        pulse(9'h001);
        frame();
        chk("sat_hold", int'(o_score), 255);

        // Randomized traffic against the model.
        for (int it = 0; it < 700; it++) begin
            int r, x, y;
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                cur_t = 9'($urandom);
                if ($urandom_range(0, 1) == 1) cur_h = cur_h ^ 9'($urandom);
                frame();
                chk("rnd_score", int'(o_score), m_score);
            end else if (r < 7) begin
                cur_h = cur_h ^ (9'h001 << $urandom_range(0, 8));
                drive(1'b0, 1'b0, 0, 0);
            end else begin
                if (r < 12) begin
                    x = OX + PX * int'($urandom_range(0, 2)) + int'($urandom_range(0, 81)) - 1;
                    y = OY + PY * int'($urandom_range(0, 2)) + int'($urandom_range(0, 81)) - 1;
                end else begin
                    x = int'($urandom_range(0, 639));
                    y = int'($urandom_range(0, 479));
                end
                check_pix("rnd_pix", x, y);
            end
        end

        // Reset during a HIT flash.
        cur_h = '0; cur_t = 9'h001;
        frames(2 * FF + 4);
        pulse(9'h001);
        frame();
        check_const("pre_rst_green", 140, 100, 12'h0F0);
        RST = 1'b1;
        #1;
        chk("rst_rgb_now", rgb(), 0);
        chk("rst_score_now", int'(o_score), 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        cur_t = '0;
        frame();
        check_const("post_rst_red", 140, 100, 12'hF00);
        chk("post_rst_score", int'(o_score), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
